// File: rtl/reaction_game_ctrl.sv
// Reaction-timer game sequencer: button synchronisers, game FSM, arm/go counters,
// timer-chain control, GO LEDs and best-score register.
module reaction_game_ctrl #(
    parameter int unsigned MIN_DELAY   = 500,
    parameter int unsigned TIMEOUT_MS  = 9999,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock50M,
    input  logic        reset_n,
    input  logic        tick_1k,
    input  logic        enable,
    input  logic        start_n,
    input  logic        react_n,
    input  logic        clear_best,
    input  logic [11:0] rand_delay,
    input  logic [23:0] elapsed,
    output logic        timer_clr,
    output logic        timer_en,
    output logic [9:0]  led_go,
    output logic        foul,
    output logic        timeout,
    output logic        new_best,
    output logic [23:0] best_score,
    output logic [2:0]  state
);

    localparam int unsigned CNT_W = 14;
    localparam int unsigned LED_W = 10;
    localparam int unsigned BCD_W = 24;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_GO      = 3'd2,
        S_DONE    = 3'd3,
        S_FOUL    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   delay_cnt, delay_d;
    logic [CNT_W-1:0]   ms_cnt, ms_d;
    logic               done_first, done_first_d;
    logic [BCD_W-1:0]   best_d;
    logic               arm_load_c;
    logic               best_update_c;
    logic               new_best_d;

    logic [SYNC_STAGES-1:0] start_sync, react_sync;
    logic                   start_prev, react_prev;
    logic                   start_press_c, react_press_c;

    // Synchronise the raw keys (released = 1) and detect the 1->0 edge
    always_ff @(posedge clock50M or negedge reset_n) begin
        if (!reset_n) begin
            start_sync <= '1;
            react_sync <= '1;
            start_prev <= 1'b1;
            react_prev <= 1'b1;
        end else begin
            start_sync <= SYNC_STAGES'({start_sync, start_n});
            react_sync <= SYNC_STAGES'({react_sync, react_n});
            start_prev <= start_sync[SYNC_STAGES-1];
            react_prev <= react_sync[SYNC_STAGES-1];
        end
    end

    assign start_press_c = start_prev & ~start_sync[SYNC_STAGES-1];
    assign react_press_c = react_prev & ~react_sync[SYNC_STAGES-1];

    // Next state and counter updates
    always_comb begin
        state_d      = state_q;
        delay_d      = delay_cnt;
        ms_d         = ms_cnt;
        arm_load_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_press_c) arm_load_c = 1'b1;
            end
            S_ARM: begin
                if (react_press_c) begin
                    state_d = S_FOUL;
                end else if (tick_1k) begin
                    if (delay_cnt <= CNT_W'(1)) state_d = S_GO;
                    else                        delay_d = delay_cnt - CNT_W'(1);
                end
            end
            S_GO: begin
                if (react_press_c) begin
                    state_d = S_DONE;
                end else if (tick_1k) begin
                    if (ms_cnt == CNT_W'(TIMEOUT_MS - 1)) state_d = S_TIMEOUT;
                    else                                  ms_d = ms_cnt + CNT_W'(1);
                end
            end
            S_DONE, S_FOUL, S_TIMEOUT: begin
                if (start_press_c) arm_load_c = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (arm_load_c) begin
            state_d = S_ARM;
            delay_d = CNT_W'(rand_delay) + CNT_W'(MIN_DELAY);
        end
        if (state_d == S_GO && state_q != S_GO) ms_d = '0;

        // Switch off overrides every other transition
        if (!enable) begin
            state_d    = S_IDLE;
            arm_load_c = 1'b0;
        end
        done_first_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    // Best-score update on the first DONE cycle; BCD compares like binary
    always_comb begin
        best_update_c = (state_q == S_DONE) && done_first && enable &&
                        (elapsed != '0) &&
                        ((best_score == '0) || (elapsed < best_score));
        best_d = best_score;
        if (best_update_c) best_d = elapsed;
        if (clear_best)    best_d = '0;
        new_best_d = (state_d == S_DONE) &&
                     (new_best || (best_update_c && !clear_best));
    end

    always_ff @(posedge clock50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            delay_cnt  <= '0;
            ms_cnt     <= '0;
            done_first <= 1'b0;
            timer_clr  <= 1'b0;
            timer_en   <= 1'b0;
            led_go     <= '0;
            foul       <= 1'b0;
            timeout    <= 1'b0;
            new_best   <= 1'b0;
            best_score <= '0;
        end else begin
            state_q    <= state_d;
            delay_cnt  <= delay_d;
            ms_cnt     <= ms_d;
            done_first <= done_first_d;
            timer_clr  <= arm_load_c;
            timer_en   <= (state_d == S_GO);
            led_go     <= {LED_W{state_d == S_GO}};
            foul       <= (state_d == S_FOUL);
            timeout    <= (state_d == S_TIMEOUT);
            new_best   <= new_best_d;
            best_score <= best_d;
        end
    end

    assign state = state_q;

endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
- Central sequencer for the reaction-timer game. It owns the game FSM: idle, random arm delay, timed go window, result, foul and timeout.
- It drives clear/enable of the 6-digit BCD count-timer chain and the GO LEDs, and keeps the best (lowest) score register.
- It sits between the push-button/switch inputs, the 1 kHz tick from the clock divider, the LFSR, and the display muxing.

Parameters:
- MIN_DELAY, 500, ms added to the random delay before GO.
- TIMEOUT_MS, 9999, ms in GO without a reaction before TIMEOUT.
- SYNC_STAGES, 2, synchroniser flops on each button input.

Ports:
- clock50M  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- tick_1k  input  1  one-clock50M-cycle pulse every 1 ms.
- enable  input  1  game enabled (switch); low forces IDLE.
- start_n  input  1  raw start key, active-low.
- react_n  input  1  raw react key, active-low.
- clear_best  input  1  synchronous clear of the best score.
- rand_delay  input  12  LFSR value in ms, sampled on ARM entry.
- elapsed  input  24  BCD count from the timer chain, 6 digits, digit0 = ms.
- timer_clr  output  1  clear to the timer chain.
- timer_en  output  1  count enable to the timer chain.
- led_go  output  10  all-ones in GO, else zero.
- foul  output  1  high while in FOUL.
- timeout  output  1  high while in TIMEOUT.
- new_best  output  1  high during DONE when the last result set a new best.
- best_score  output  24  BCD best score; 0 = none recorded.
- state  output  3  current state encoding, for debug/display select.

Behaviour:
- Reset (reset_n low, async):
  - state = IDLE. All outputs 0. best_score = 0. Internal counters = 0. Synchroniser flops preset to 1 (released).
- Button press detection:
  - SYNC_STAGES-flop synchroniser, then an edge detector.
  - A press is a one-cycle pulse on a synchronised 1->0 transition. Holding a key does not repeat.
- States and encodings: IDLE=0, ARM=1, GO=2, DONE=3, FOUL=4, TIMEOUT=5. Encodings 6-7 recover to IDLE on the next clock.
- enable low in any state: IDLE on the next clock. Overrides all other transitions.
- IDLE:
  - start press with enable high -> ARM.
  - In the transition cycle: delay_cnt <= rand_delay + MIN_DELAY (14-bit, no overflow), and timer_clr = 1 for exactly one cycle.
- ARM:
  - delay_cnt decrements on each tick_1k.
  - A tick with delay_cnt==1 -> GO. If delay_cnt loads as 0, -> GO on the first tick.
  - react press -> FOUL. React has priority over a same-cycle expiring tick.
  - start press is ignored.
- GO:
  - timer_en = 1 and led_go = 10'h3FF, both registered and asserted from the first GO cycle.
  - ms_cnt (14-bit) is cleared on entry and increments on tick_1k.
  - react press -> DONE. timer_en drops in the same clock that enters DONE.
  - A tick with ms_cnt==TIMEOUT_MS-1, without a same-cycle react -> TIMEOUT. React wins a simultaneous event.
- DONE:
  - On the first DONE cycle, sample elapsed. The comparison is numeric on BCD digits, digit5 most significant.
  - If (best_score==0 or elapsed<best_score) and elapsed!=0: best_score <= elapsed, and new_best = 1 for the rest of DONE.
  - An elapsed value of 0 never updates best_score.
- DONE, FOUL, TIMEOUT:
  - start press -> ARM, with the same load and timer_clr pulse as from IDLE.
  - react press is ignored.
  - new_best, foul and timeout clear on exit.
- clear_best sets best_score = 0 next cycle in any state. If it coincides with the DONE update, clear wins.
- timer_clr is never asserted together with timer_en.
- tick_1k is ignored outside ARM and GO.

Test Plan:
- Reset, enable=1, rand_delay=12'd100, press start -> timer_clr one pulse. ARM lasts exactly 600 ticks, then GO with led_go=3FF and timer_en=1.
- In GO, press react after the bench drives elapsed=24'h000287 -> DONE, timer_en=0 the same clock, best_score=000287, new_best=1.
- Second round with elapsed=24'h000312 -> best_score stays 000287 and new_best=0. Third round with 000150 -> best_score=000150 and new_best=1.
- Press react 10 ticks into ARM -> FOUL, foul=1, timer_en never asserted, best_score unchanged. Start press -> ARM with a new timer_clr pulse.
- No react in GO -> TIMEOUT after exactly 9999 ticks, timeout=1. React and the final tick in the same cycle -> DONE instead.
- Drop enable mid-GO -> IDLE next clock with led_go=0. Assert reset_n low mid-ARM -> all outputs 0 immediately. Assert clear_best -> best_score=0.
